// File: rtl/fifo_pkg.sv
// Shared helpers for the programmable synchronous FIFO.
// ptr_next(): advance a circular pointer over 0..depth-1 with an explicit
// wrap, so the storage depth does not have to be a power of two.
package fifo_pkg;

    // Next value of a circular pointer: wraps to 0 after depth-1.
    function automatic logic [31:0] ptr_next(input logic [31:0] ptr,
                                             input logic [31:0] depth);
        logic [31:0] nxt_s;
        if (ptr == (depth - 32'd1)) begin
            nxt_s = 32'd0;
        end else begin
            nxt_s = ptr + 32'd1;
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle of sync_fifo_prog.
// slave  : the FIFO side (takes requests, thresholds, flush; drives data/status)
// master : the user side (drives requests and thresholds, observes status)
// Signals: flush, wr_en, wr_data, rd_en, rd_data, rd_valid, af_thresh,
//          ae_thresh, count, full, empty, almost_full, almost_empty,
//          overflow, underflow.
interface sync_fifo_prog_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] af_thresh;
    logic [CNT_W-1:0] ae_thresh;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport slave (
        input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        output rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport master (
        output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh,
        input  rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Control core of sync_fifo_prog: read/write pointers, occupancy count,
// status flags and the overflow/underflow error pulses.
// Ports: clk, rst (async, active-high), flush (sync clear), wr_en, rd_en,
//        af_thresh/ae_thresh (live thresholds), wr_acc (write strobe for
//        the storage), wr_ptr/rd_ptr, count, full, empty, almost_full,
//        almost_empty, overflow, underflow.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [CNT_W-1:0] af_thresh,
    input  logic [CNT_W-1:0] ae_thresh,
    output logic             wr_acc,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_acc_s;
    logic             rd_acc_s;

    assign full_s  = (count_r == CNT_W'(DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Acceptance: a write into a full FIFO is allowed when a read frees a
    // slot in the same cycle; a read never borrows the same-cycle write.
    always_comb begin
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        if (flush) begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
        end else begin
            rd_acc_s = rd_en && !empty_s;
            wr_acc_s = wr_en && (!full_s || rd_acc_s);
        end
    end

    // Pointer, occupancy and error-pulse state; flush overrides traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= PTR_W'(ptr_next(32'(wr_ptr_r), 32'(DEPTH)));
            end
            if (rd_acc_s) begin
                rd_ptr_r <= PTR_W'(ptr_next(32'(rd_ptr_r), 32'(DEPTH)));
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            overflow_r  <= wr_en && !wr_acc_s;
            underflow_r <= rd_en && !rd_acc_s;
        end
    end

    assign wr_acc       = wr_acc_s;
    assign wr_ptr       = wr_ptr_r;
    assign rd_ptr       = rd_ptr_r;
    assign count        = count_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= af_thresh);
    assign almost_empty = (count_r <= ae_thresh);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of any DEPTH >= 2 with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush, error pulses and
// an optional first-word-fall-through read mode (FWFT=1).
// Ports: clk, rst (async, active-high), bus (sync_fifo_prog_if.slave):
//        flush, wr_en, wr_data, rd_en, rd_data, rd_valid, af_thresh,
//        ae_thresh, count, full, empty, almost_full, almost_empty,
//        overflow, underflow.
// The storage array holds no reset; flush/reset only move the pointers.
module sync_fifo_prog #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int FWFT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_prog_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_acc_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.flush),
        .wr_en        (bus.wr_en),
        .rd_en        (bus.rd_en),
        .af_thresh    (bus.af_thresh),
        .ae_thresh    (bus.ae_thresh),
        .wr_acc       (wr_acc_s),
        .wr_ptr       (wr_ptr_s),
        .rd_ptr       (rd_ptr_s),
        .count        (bus.count),
        .full         (bus.full),
        .empty        (bus.empty),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow)
    );

    // Storage write on every accepted write.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_s] <= bus.wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so the
            // output is clean after reset/flush.
            assign bus.rd_data  = bus.empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_s];
            assign bus.rd_valid = !bus.empty;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_r;
            logic             rd_valid_r;

            // Registered read: same acceptance as the controller (not empty,
            // no flush), data and valid one cycle after the request.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_r  <= {WIDTH{1'b0}};
                    rd_valid_r <= 1'b0;
                end else if (bus.flush) begin
                    rd_data_r  <= {WIDTH{1'b0}};
                    rd_valid_r <= 1'b0;
                end else if (bus.rd_en && !bus.empty) begin
                    rd_data_r  <= mem_r[rd_ptr_s];
                    rd_valid_r <= 1'b1;
                end else begin
                    rd_valid_r <= 1'b0;
                end
            end

            assign bus.rd_data  = rd_data_r;
            assign bus.rd_valid = rd_valid_r;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a DEPTH=6 standard-read instance
// driven from a vector table plus hand sequences, and a DEPTH=6 FWFT
// instance exercised by a short hand sequence.
module tb_sync_fifo_prog;

    localparam int W = 8;
    localparam int D = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_prog_if #(.WIDTH(W), .DEPTH(D)) s_if ();
    sync_fifo_prog_if #(.WIDTH(W), .DEPTH(D)) f_if ();

    sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .clk (clk), .rst (rst), .bus (s_if)
    );
    sync_fifo_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fw (
        .clk (clk), .rst (rst), .bus (f_if)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [2:0] af;
        logic [2:0] ae;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic       rv;
        logic [7:0] rdat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [7:0] din,
                       input logic [2:0] af, input logic [2:0] ae, input int cnt,
                       input logic ovf, input logic unf, input logic rv,
                       input logic [7:0] rdat);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.af = af; v.ae = ae; v.cnt = cnt;
        v.ovf = ovf; v.unf = unf; v.rv = rv; v.rdat = rdat;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if.flush = 1'b0; s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
        s_if.wr_data = 8'h00; s_if.af_thresh = 3'd5; s_if.ae_thresh = 3'd1;
        f_if.flush = 1'b0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
        f_if.wr_data = 8'h00; f_if.af_thresh = 3'd5; f_if.ae_thresh = 3'd1;

        // ---- reset state ----
        #2;
        chk("rst_count", 32'(s_if.count), 32'd0);
        chk("rst_empty", 32'(s_if.empty), 32'd1);
        chk("rst_full", 32'(s_if.full), 32'd0);
        chk("rst_ae", 32'(s_if.almost_empty), 32'd1);
        chk("rst_af", 32'(s_if.almost_full), 32'd0);
        chk("rst_rv", 32'(s_if.rd_valid), 32'd0);
        chk("rst_rdata", 32'(s_if.rd_data), 32'd0);
        step();
        rst = 1'b0;

        // ---- reset in the middle of traffic ----
        for (int i = 1; i <= 3; i++) begin
            s_if.wr_en = 1'b1; s_if.wr_data = 8'(i);
            step();
        end
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b1;
        step();
        chk("mid_rv_pre", 32'(s_if.rd_valid), 32'd1);
        chk("mid_rd_pre", 32'(s_if.rd_data), 32'h01);
        s_if.wr_en = 1'b1; s_if.wr_data = 8'h99;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(s_if.count), 32'd0);
        chk("mid_rst_empty", 32'(s_if.empty), 32'd1);
        chk("mid_rst_rv", 32'(s_if.rd_valid), 32'd0);
        chk("mid_rst_rdata", 32'(s_if.rd_data), 32'd0);
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
        step();
        rst = 1'b0;
        s_if.wr_en = 1'b1; s_if.wr_data = 8'h77;
        step();
        chk("post_rst_count", 32'(s_if.count), 32'd1);
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b1;
        step();
        chk("post_rst_rd", 32'(s_if.rd_data), 32'h77);
        chk("post_rst_rv", 32'(s_if.rd_valid), 32'd1);
        chk("post_rst_cnt0", 32'(s_if.count), 32'd0);
        s_if.rd_en = 1'b0;

        // ---- vector table: fill/drain, overflow/underflow, simultaneous, thresholds ----
        add(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 0, 1'b0, 1'b0, 1'b0, 8'h77);
        for (int i = 0; i < 6; i++)
            add(1'b1, 1'b0, 8'(8'h10 + i), 3'd5, 3'd1, i + 1, 1'b0, 1'b0, 1'b0, 8'h77);
        add(1'b1, 1'b0, 8'h16, 3'd5, 3'd1, 6, 1'b1, 1'b0, 1'b0, 8'h77);
        for (int i = 0; i < 6; i++)
            add(1'b0, 1'b1, 8'h00, 3'd5, 3'd1, 5 - i, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
        add(1'b0, 1'b1, 8'h00, 3'd5, 3'd1, 0, 1'b0, 1'b1, 1'b0, 8'h15);
        add(1'b1, 1'b1, 8'h20, 3'd5, 3'd1, 1, 1'b0, 1'b1, 1'b0, 8'h15);
        for (int i = 1; i <= 5; i++)
            add(1'b1, 1'b0, 8'(8'h20 + i), 3'd5, 3'd1, i + 1, 1'b0, 1'b0, 1'b0, 8'h15);
        add(1'b1, 1'b1, 8'h26, 3'd5, 3'd1, 6, 1'b0, 1'b0, 1'b1, 8'h20);
        for (int i = 0; i < 6; i++)
            add(1'b0, 1'b1, 8'h00, 3'd5, 3'd1, 5 - i, 1'b0, 1'b0, 1'b1, 8'(8'h21 + i));

        foreach (vecs[k]) begin
            s_if.wr_en = vecs[k].wr; s_if.rd_en = vecs[k].rd; s_if.wr_data = vecs[k].din;
            s_if.af_thresh = vecs[k].af; s_if.ae_thresh = vecs[k].ae;
            step();
            chk($sformatf("v%0d_count", k), 32'(s_if.count), 32'(vecs[k].cnt));
            chk($sformatf("v%0d_full", k), 32'(s_if.full), 32'(vecs[k].cnt == D));
            chk($sformatf("v%0d_empty", k), 32'(s_if.empty), 32'(vecs[k].cnt == 0));
            chk($sformatf("v%0d_af", k), 32'(s_if.almost_full), 32'(vecs[k].cnt >= int'(vecs[k].af)));
            chk($sformatf("v%0d_ae", k), 32'(s_if.almost_empty), 32'(vecs[k].cnt <= int'(vecs[k].ae)));
            chk($sformatf("v%0d_ovf", k), 32'(s_if.overflow), 32'(vecs[k].ovf));
            chk($sformatf("v%0d_unf", k), 32'(s_if.underflow), 32'(vecs[k].unf));
            chk($sformatf("v%0d_rv", k), 32'(s_if.rd_valid), 32'(vecs[k].rv));
            chk($sformatf("v%0d_rdata", k), 32'(s_if.rd_data), 32'(vecs[k].rdat));
        end
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
        s_if.af_thresh = 3'd5; s_if.ae_thresh = 3'd1;

        // ---- pointer wrap: 20 bursts of 4 writes then 4 reads ----
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < 4; k++) begin
                s_if.wr_en = 1'b1; s_if.wr_data = 8'(8'h40 + b * 4 + k);
                step();
            end
            s_if.wr_en = 1'b0;
            for (int k = 0; k < 4; k++) begin
                s_if.rd_en = 1'b1;
                step();
                chk($sformatf("wrap_b%0d_k%0d", b, k), 32'(s_if.rd_data), 32'(8'(8'h40 + b * 4 + k)));
            end
            s_if.rd_en = 1'b0;
            chk($sformatf("wrap_b%0d_cnt", b), 32'(s_if.count), 32'd0);
        end

        // ---- FWFT instance ----
        f_if.wr_en = 1'b1; f_if.wr_data = 8'hA5;
        #1;
        chk("fw_pre_rv", 32'(f_if.rd_valid), 32'd0);
        step();
        f_if.wr_en = 1'b0;
        chk("fw_rv", 32'(f_if.rd_valid), 32'd1);
        chk("fw_rdata", 32'(f_if.rd_data), 32'hA5);
        chk("fw_count1", 32'(f_if.count), 32'd1);
        step();
        chk("fw_hold_rdata", 32'(f_if.rd_data), 32'hA5);
        f_if.rd_en = 1'b1;
        step();
        f_if.rd_en = 1'b0;
        chk("fw_pop_empty", 32'(f_if.empty), 32'd1);
        chk("fw_pop_rv", 32'(f_if.rd_valid), 32'd0);
        chk("fw_pop_unf", 32'(f_if.underflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            f_if.wr_en = 1'b1; f_if.wr_data = 8'(8'hB0 + i);
            step();
        end
        f_if.wr_en = 1'b0;
        chk("fw_count4", 32'(f_if.count), 32'd4);
        chk("fw_head", 32'(f_if.rd_data), 32'hB0);
        f_if.flush = 1'b1; f_if.wr_en = 1'b1; f_if.rd_en = 1'b1; f_if.wr_data = 8'hEE;
        step();
        f_if.flush = 1'b0; f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
        chk("fl_count", 32'(f_if.count), 32'd0);
        chk("fl_empty", 32'(f_if.empty), 32'd1);
        chk("fl_ovf", 32'(f_if.overflow), 32'd0);
        chk("fl_unf", 32'(f_if.underflow), 32'd0);
        chk("fl_rv", 32'(f_if.rd_valid), 32'd0);
        f_if.wr_en = 1'b1; f_if.wr_data = 8'hC3;
        step();
        f_if.wr_en = 1'b0;
        chk("fl_after_rdata", 32'(f_if.rd_data), 32'hC3);
        chk("fl_after_count", 32'(f_if.count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
